// File: rtl/sobel_frame_sequencer.sv
// Frame sequencer for the Sobel core: streams a frame from pixel RAM through a
// 2-entry skid FIFO, pacing rows by the core's interrupt-driven buffer credits.
module sobel_frame_sequencer #(
    parameter int IMG_W         = 512,
    parameter int IMG_H         = 512,
    parameter int PREFILL_LINES = 4,
    parameter int PAD_LINES     = 2,
    parameter int ADDR_W        = 18
) (
    input  logic              axi_clk,
    input  logic              axi_reset,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_mem_rd_en,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic [7:0]        i_mem_rd_data,
    output logic              o_data_valid,
    output logic [7:0]        o_data,
    input  logic              i_data_ready,
    input  logic              i_intr,
    input  logic              i_out_valid
);
    localparam int PIX   = IMG_W * IMG_H;
    localparam int CNT_W = $clog2(PIX) + 1;
    localparam int ROW_W = $clog2(IMG_H + PAD_LINES + 1);

    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREFILL_LINES * IMG_W - 1);
    localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(IMG_W - 1);
    localparam logic [CNT_W-1:0] PIX_CNT  = CNT_W'(PIX);
    localparam logic [ROW_W-1:0] PRE_ROWS = ROW_W'(PREFILL_LINES);
    localparam logic [ROW_W-1:0] IMG_ROWS = ROW_W'(IMG_H);
    localparam logic [ROW_W-1:0] PAD_ROWS = ROW_W'(PAD_LINES);

    typedef enum logic [2:0] {
        IDLE, PREFILL, WAIT_CRED, LINE, PAD, DRAIN, DONE
    } state_t;

    state_t            state, state_nxt;
    logic              intr_d;
    logic [1:0]        credits;
    logic [CNT_W-1:0]  issue_cnt;
    logic [CNT_W-1:0]  out_count;
    logic [ROW_W-1:0]  img_rows;
    logic [ROW_W-1:0]  pad_rows;
    logic [ADDR_W-1:0] addr;
    logic              inflight;
    logic              inflight_zero;
    logic [7:0]        fifo_mem [2];
    logic              fifo_wr;
    logic              fifo_rd;
    logic [1:0]        used;
    logic [2:0]        occ;
    logic              start_ok;
    logic              intr_rise;
    logic              pop;
    logic              issue;
    logic              phase_last;
    logic              take_credit;

    assign start_ok  = (state == IDLE) && i_start;
    assign intr_rise = i_intr && !intr_d;
    assign pop       = o_data_valid && i_data_ready;

    // Occupancy after this cycle's pop and pending push; keeps full rate while never overfilling.
    assign occ   = {1'b0, used} + {2'b0, inflight} - {2'b0, pop};
    assign issue = (state inside {PREFILL, LINE, PAD}) && (occ < 3'd2);
    assign phase_last = issue &&
        ((state == PREFILL) ? (issue_cnt == PRE_LAST) : (issue_cnt == ROW_LAST));

    assign o_busy       = (state != IDLE);
    assign o_done       = (state == DONE);
    assign o_mem_rd_en  = issue && (state != PAD);
    assign o_mem_addr   = addr;
    assign o_data_valid = (used != 2'd0);
    assign o_data       = o_data_valid ? fifo_mem[fifo_rd] : 8'd0;

    always_comb begin
        state_nxt   = state;
        take_credit = 1'b0;
        case (state)
            IDLE:      if (i_start) state_nxt = PREFILL;
            PREFILL:   if (phase_last) state_nxt = WAIT_CRED;
            WAIT_CRED: begin
                if (img_rows != IMG_ROWS) begin
                    if (credits != 2'd0) begin
                        state_nxt   = LINE;
                        take_credit = 1'b1;
                    end
                end else if (pad_rows != PAD_ROWS) begin
                    if (credits != 2'd0) begin
                        state_nxt   = PAD;
                        take_credit = 1'b1;
                    end
                end else begin
                    state_nxt = DRAIN;
                end
            end
            LINE, PAD: if (phase_last) state_nxt = WAIT_CRED;
            DRAIN:     if (out_count == PIX_CNT && used == 2'd0 && !inflight) state_nxt = DONE;
            DONE:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            state         <= IDLE;
            intr_d        <= 1'b0;
            credits       <= 2'd0;
            issue_cnt     <= '0;
            out_count     <= '0;
            img_rows      <= '0;
            pad_rows      <= '0;
            addr          <= '0;
            inflight      <= 1'b0;
            inflight_zero <= 1'b0;
            fifo_wr       <= 1'b0;
            fifo_rd       <= 1'b0;
            used          <= 2'd0;
        end else begin
            state         <= state_nxt;
            intr_d        <= i_intr;
            inflight      <= issue;
            inflight_zero <= (state == PAD);
            used          <= occ[1:0];
            if (inflight) fifo_wr <= !fifo_wr;
            if (pop)      fifo_rd <= !fifo_rd;

            // Credits saturate at 3; a coincident edge and consume cancel out.
            if (start_ok) begin
                credits <= 2'd0;
            end else if (state != IDLE) begin
                if (intr_rise && !take_credit && credits != 2'd3)
                    credits <= credits + 2'd1;
                else if (take_credit && !intr_rise)
                    credits <= credits - 2'd1;
            end

            if (start_ok) begin
                issue_cnt <= '0;
                out_count <= '0;
                img_rows  <= '0;
                pad_rows  <= '0;
                addr      <= '0;
            end else begin
                if (issue) issue_cnt <= phase_last ? '0 : issue_cnt + CNT_W'(1);
                if (o_mem_rd_en) addr <= addr + ADDR_W'(1);
                if (phase_last) begin
                    if (state == PREFILL)   img_rows <= PRE_ROWS;
                    else if (state == LINE) img_rows <= img_rows + ROW_W'(1);
                    else                    pad_rows <= pad_rows + ROW_W'(1);
                end
                if (i_out_valid && state != IDLE) out_count <= out_count + CNT_W'(1);
            end
        end
    end

    // Skid storage carries data only; occupancy and pointers above carry reset.
    always_ff @(posedge axi_clk) begin
        if (inflight) fifo_mem[fifo_wr] <= inflight_zero ? 8'd0 : i_mem_rd_data;
    end

endmodule
